glu_act_scheduler: RTL and testbench
====================================

// Module: glu_act_scheduler
// PURPOSE
//  Round-robin arbiter and sequencer sharing one combinational GLU activation unit (Q4.12, 16-bit)
//  among NUM_REQ layer engines of the 3x3 GAN. Grants a whole burst (until last) to one requester,
//  drives the shared unit's input, registers its result and returns it tagged with the requester id.
// PARAMETERS
//  NUM_REQ    4    number of requesters (>=2)
//  ID_W       2    width of out_id; must equal clog2(NUM_REQ)
//  MAX_BURST  64   max elements per grant; longer bursts are truncated
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          asynchronous reset, active-high
//  req_valid  in   NUM_REQ    per-requester element valid
//  req_last   in   NUM_REQ    per-requester last element of burst
//  req_data   in   16*NUM_REQ packed Q4.12 samples; requester i at [16*i+:16]
//  req_ready  out  NUM_REQ    per-requester accept
//  glu_in     out  16         to shared GLU unit d_in
//  glu_out    in   16         from shared GLU unit d_out (combinational)
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accept
//  out_data   out  16         registered GLU result, Q4.12
//  out_last   out  1          last of burst (real or truncated)
//  out_id     out  ID_W       requester index of out_data
//  busy       out  1          high while in BUSY
//  trunc      out  1          one-cycle pulse when a burst is truncated
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt=0, beat_cnt=0; out_valid=0, out_data=0, out_last=0, out_id=0,
//   trunc=0, busy=0, req_ready=0. Reset mid-burst drops any pending output word; no partial recovery.
//  FSM: IDLE -> BUSY when any req_valid; gnt = first valid index searching rr_ptr, rr_ptr+1, ...
//   (mod NUM_REQ). Grant registered; first transfer earliest cycle after leaving IDLE.
//   BUSY -> IDLE on the cycle a transfer with req_last[gnt]=1 or truncation occurs; same edge
//   rr_ptr <= (gnt+1) mod NUM_REQ. No direct BUSY->BUSY re-grant (1 idle cycle between bursts).
//  req_ready[i] = (state==BUSY) && (i==gnt) && (!out_valid || out_ready); all others 0.
//  Transfer = req_valid[gnt] && req_ready[gnt]. glu_in = req_data[gnt] in BUSY, 16'h0000 in IDLE.
//  Latency: transfer in cycle N -> out_data=glu_out, out_id=gnt, out_valid=1 at edge ending N.
//   Full throughput (1/cycle) while out_ready=1. out_valid && !out_ready holds all out_* stable.
//  Output register clears out_valid on out_ready unless a new transfer reloads it same cycle.
//  beat_cnt: reset to 0 on grant, +1 per transfer. Transfer with beat_cnt==MAX_BURST-1 and
//   req_last=0: out_last forced 1, trunc pulses next cycle, burst ends; remainder of that stream
//   is served under a later grant as a new burst.
//  Requester dropping req_valid mid-burst: grant held, no timeout.
//  Arithmetic: none in this block; data passes through the GLU unaltered in width.
// CONFIGURATION
//  GLU_SCHED_STATS_EN defined: adds output stat_bursts[NUM_REQ*16-1:0], per-requester count of
//   completed bursts (real or truncated), 16-bit wrapping (0xFFFF+1 -> 0), cleared by rst.
//  Undefined: port absent, no counters synthesised; all other behaviour identical.
// TESTING (glu_out tied to identity stub unless noted)
//  1 Reset: assert rst mid-burst with out_valid=1 -> out_valid=0, busy=0, req_ready=0 immediately.
//  2 Req1 bursts 3 words 0x1000,0x2000,0x3000 (last on 3rd), out_ready=1 -> out_data same order,
//    out_id=1, out_last only on 0x3000, one word/cycle, busy drops after last transfer.
//  3 All 4 requesters valid with 1-word bursts from reset -> grant order 0,1,2,3,0; rr_ptr wraps.
//  4 Backpressure: out_ready=0 for 5 cycles mid-burst -> req_ready[gnt]=0, out_* held, no loss.
//  5 MAX_BURST=4, req2 sends 6 words no last -> out_last on 4th, trunc pulse, next grant to req3
//    if valid else req2 resumes with words 5-6.
//  6 Real GLU attached: inputs 0x0000, 0x1000, 0xF000 -> out_data matches glu reference model.

Source files
------------

// File: rtl/glu_act_scheduler.sv
// Round-robin scheduler sharing one combinational GLU among NUM_REQ engines; whole bursts per grant.
// Latency: 1 cycle, transfer -> registered out_data. Backpressure: out_valid && !out_ready stalls req_ready[gnt].
// Optional GLU_SCHED_STATS_EN adds per-requester completed-burst counters on stat_bursts.
module glu_act_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int MAX_BURST = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_last,
  input  logic [16*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [15:0]             glu_in,
  input  logic [15:0]             glu_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_data,
  output logic                    out_last,
  output logic [ID_W-1:0]         out_id,
  output logic                    busy,
  output logic                    trunc
`ifdef GLU_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   stat_bursts
`endif
);

  localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, gnt, pick;
  logic [BC_W-1:0] beat_cnt;
  logic            any_vld, xfer, last_beat, cut, at_max;

  // First valid requester at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ])
        pick = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
    end
  end

  assign any_vld = |req_valid;
  assign at_max  = (beat_cnt == BC_W'(MAX_BURST - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    glu_in    = 16'h0000;
    busy      = 1'b0;
    xfer      = 1'b0;
    last_beat = 1'b0;
    cut       = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld) state_nxt = BUSY;
      end
      BUSY: begin
        busy           = 1'b1;
        glu_in         = req_data[16*gnt +: 16];
        req_ready[gnt] = !out_valid || out_ready;
        xfer           = req_valid[gnt] && req_ready[gnt];
        last_beat      = req_last[gnt] || at_max;
        cut            = !req_last[gnt] && at_max;
        if (xfer && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_last  <= 1'b0;
      out_id    <= '0;
      trunc     <= 1'b0;
    end else begin
      trunc <= xfer && cut;
      if (state == IDLE && any_vld) begin
        gnt      <= pick;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (xfer && last_beat)
        rr_ptr <= ID_W'((int'(gnt) + 1) % NUM_REQ);
      // A new transfer reloads the output word even while the old one drains.
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= glu_out;
        out_last  <= last_beat;
        out_id    <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef GLU_SCHED_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= 16'h0000;
    end else if (xfer && last_beat) begin
      stat_cnt[gnt] <= stat_cnt[gnt] + 16'h0001;
    end
  end

  always_comb begin
    stat_bursts = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_bursts[16*i +: 16] = stat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_glu_act_scheduler.sv
// Directed bench for glu_act_scheduler with MAX_BURST=4; glu_out is an identity stub or a
// hard-sigmoid GLU stub (x * clamp(0.5 + x/4, 0, 1)) selected by use_glu.
module tb_glu_act_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid, req_last, req_ready;
  logic [16*NUM_REQ-1:0] req_data;
  logic [15:0]           glu_in, glu_out, out_data;
  logic                  out_valid, out_ready, out_last, busy, trunc;
  logic [ID_W-1:0]       out_id;
  logic                  use_glu;
`ifdef GLU_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0] stat_bursts;
`endif

  int total = 0;
  int bad   = 0;

  glu_act_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .glu_in(glu_in), .glu_out(glu_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_id(out_id), .busy(busy), .trunc(trunc)
`ifdef GLU_SCHED_STATS_EN
    , .stat_bursts(stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] glu_stub(input logic [15:0] x);
    logic signed [15:0] xs;
    logic signed [16:0] s;
    logic signed [31:0] p;
    xs = x;
    s  = 17'sh00800 + 17'(xs >>> 2);
    if (s < 0) s = '0;
    if (s > 17'sh01000) s = 17'sh01000;
    p = 32'(xs) * 32'(s);
    p = p >>> 12;
    return p[15:0];
  endfunction

  always_comb glu_out = use_glu ? glu_stub(glu_in) : glu_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [15:0] v);
    req_data[16*i +: 16] = v;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic [ID_W-1:0] id,
                         input logic lst);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(out_data), 32'(d));
    chk({tag, "_id"}, 32'(out_id), 32'(id));
    chk({tag, "_last"}, 32'(out_last), 32'(lst));
  endtask

  initial begin
    logic [15:0] words [3];
    logic [15:0] glu_exp [3];
    int          order [5];

    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; out_ready = 1'b1; use_glu = 1'b0;
    step(); step();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);
    chk("rst_glu_in", 32'(glu_in), 32'd0);
    rst = 1'b0;
    step();

    // Req1: three-word burst at full rate.
    words = '{16'h1000, 16'h2000, 16'h3000};
    req_valid = 4'b0010; put(1, words[0]);
    step();
    chk("b1_busy", 32'(busy), 32'd1);
    chk("b1_rdy", 32'(req_ready), 32'b0010);
    chk("b1_glu_in", 32'(glu_in), 32'h1000);
    for (int w = 0; w < 3; w++) begin
      put(1, words[w]);
      req_last = (w == 2) ? 4'b0010 : 4'b0000;
      step();
      chk_out($sformatf("b1_w%0d", w), words[w], 2'd1, w == 2);
    end
    chk("b1_idle", 32'(busy), 32'd0);
    req_valid = '0; req_last = '0;
    step();
    chk("b1_drain", 32'(out_valid), 32'd0);

    // All four valid with one-word bursts from reset: round-robin 0,1,2,3,0.
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) put(i, 16'h0A00 + 16'(i));
    order = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("rr%0d_rdy", g), 32'(req_ready), 32'(1 << order[g]));
      step();
      chk_out($sformatf("rr%0d", g), 16'h0A00 + 16'(order[g]), ID_W'(order[g]), 1'b1);
    end
    req_valid = '0; req_last = '0;
    step();

    // Backpressure mid-burst on req0.
    req_valid = 4'b0001; put(0, 16'h0111);
    step();
    step();
    chk_out("bp_w0", 16'h0111, 2'd0, 1'b0);
    out_ready = 1'b0; put(0, 16'h0222);
    #1;
    chk("bp_rdy_lo", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out($sformatf("bp_hold%0d", c), 16'h0111, 2'd0, 1'b0);
      chk($sformatf("bp_rdy%0d", c), 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_hi", 32'(req_ready), 32'b0001);
    step();
    chk_out("bp_w1", 16'h0222, 2'd0, 1'b0);
    put(0, 16'h0333); req_last = 4'b0001;
    step();
    chk_out("bp_w2", 16'h0333, 2'd0, 1'b1);
    req_valid = '0; req_last = '0;
    step();

    // Req2 sends six words without last: truncated after four, then resumes.
    req_valid = 4'b0100;
    step();
    for (int w = 1; w <= 4; w++) begin
      put(2, 16'h5000 + 16'(w));
      step();
      chk_out($sformatf("tr_w%0d", w), 16'h5000 + 16'(w), 2'd2, w == 4);
      chk($sformatf("tr_pulse%0d", w), 32'(trunc), 32'(w == 4));
    end
    chk("tr_idle", 32'(busy), 32'd0);
    step();
    chk("tr_pulse_end", 32'(trunc), 32'd0);
    chk("tr_regrant", 32'(req_ready), 32'b0100);
    put(2, 16'h5005);
    step();
    chk_out("tr_w5", 16'h5005, 2'd2, 1'b0);
    put(2, 16'h5006); req_last = 4'b0100;
    step();
    chk_out("tr_w6", 16'h5006, 2'd2, 1'b1);
    req_valid = '0; req_last = '0;
    step();

    // GLU stub attached: hand-computed x * clamp(0.5 + x/4, 0, 1) in Q4.12.
    use_glu = 1'b1;
    words   = '{16'h0000, 16'h1000, 16'hF000};
    glu_exp = '{16'h0000, 16'h0C00, 16'hFC00};
    req_valid = 4'b0010; put(1, words[0]);
    step();
    for (int w = 0; w < 3; w++) begin
      put(1, words[w]);
      req_last = (w == 2) ? 4'b0010 : 4'b0000;
      step();
      chk_out($sformatf("glu_w%0d", w), glu_exp[w], 2'd1, w == 2);
    end
    req_valid = '0; req_last = '0; use_glu = 1'b0;
    step();

    // Asynchronous reset in the middle of a stalled burst.
    req_valid = 4'b1000; put(3, 16'h7777);
    step();
    step();
    chk_out("ar_pre", 16'h7777, 2'd3, 1'b0);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_vld", 32'(out_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rdy", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0; req_valid = '0; out_ready = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
